// File: rtl/alu_pkg.sv
// Shared ALU op codes, arbiter FSM encoding and flag bit positions.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_ILL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Flag vector layout is {err, v, s, z}
  localparam int FLAG_Z   = 0;
  localparam int FLAG_S   = 1;
  localparam int FLAG_V   = 2;
  localparam int FLAG_ERR = 3;

endpackage

// File: rtl/alu_arbiter_alu32.sv
// Existing 32-bit combinational ALU; the reserved op code yields zero.
module alu32
  import alu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [2:0]  i_op,
  output logic [31:0] o_result
);

  always_comb begin
    o_result = '0;
    case (i_op)
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_SLT:  o_result = {31'b0, ($signed(i_a) < $signed(i_b))};
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_NOR:  o_result = ~(i_a | i_b);
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one ALU: IDLE accept, one EXEC cycle, RESP held until taken.
// ALU_ARB_FIXED_PRIO_EN selects fixed priority (req0 wins); default build is round-robin.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp_result,
  output logic [3:0]  resp_flags
);

  state_t            r_state;
  state_t            w_nxt_state;
  logic [NREQ-1:0]   w_valid;
  logic [NREQ-1:0]   w_gnt;
  logic              w_accept;
  logic              w_resp_take;
  logic              r_gnt_sel;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic [2:0]        r_op;
  logic [31:0]       r_result;
  logic [3:0]        r_flags;
  logic [31:0]       w_alu_res;
  logic [3:0]        w_flags;

  assign w_valid  = {req1_valid, req0_valid};
  assign w_accept = (r_state == ST_IDLE) && (|w_valid);

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_gnt = w_valid[0] ? 2'b01 : {w_valid[1], 1'b0};
`else
  // r_prio set means requester 1 is favoured on the next contention
  logic r_prio;

  assign w_gnt = (&w_valid) ? (r_prio ? 2'b10 : 2'b01) : w_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (w_accept) begin
      r_prio <= w_gnt[0];
    end
  end
`endif

  assign w_resp_take = r_gnt_sel ? resp1_ready : resp0_ready;

  always_comb begin
    w_nxt_state = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req0_ready = w_gnt[0];
        req1_ready = w_gnt[1];
        if (|w_valid) begin
          w_nxt_state = ST_EXEC;
        end
      end
      ST_EXEC: w_nxt_state = ST_RESP;
      ST_RESP: begin
        if (w_resp_take) begin
          w_nxt_state = ST_IDLE;
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  alu32 u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (r_op),
    .o_result (w_alu_res)
  );

  // Overflow derived from operand and result signs, not from the ALU
  always_comb begin
    w_flags           = '0;
    w_flags[FLAG_Z]   = (w_alu_res == '0);
    w_flags[FLAG_S]   = w_alu_res[31];
    case (r_op)
      OP_ADD:  w_flags[FLAG_V]   = (r_a[31] == r_b[31]) && (w_alu_res[31] != r_a[31]);
      OP_SUB:  w_flags[FLAG_V]   = (r_a[31] != r_b[31]) && (w_alu_res[31] != r_a[31]);
      OP_ILL:  w_flags[FLAG_ERR] = 1'b1;
      default: w_flags[FLAG_V]   = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_gnt_sel <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_result  <= '0;
      r_flags   <= '0;
    end else begin
      r_state <= w_nxt_state;
      if (w_accept) begin
        r_gnt_sel <= w_gnt[1];
        r_a       <= w_gnt[1] ? req1_a  : req0_a;
        r_b       <= w_gnt[1] ? req1_b  : req0_b;
        r_op      <= w_gnt[1] ? req1_op : req0_op;
      end
      if (r_state == ST_EXEC) begin
        r_result <= w_alu_res;
        r_flags  <= w_flags;
      end
    end
  end

  assign resp0_valid = (r_state == ST_RESP) && !r_gnt_sel;
  assign resp1_valid = (r_state == ST_RESP) &&  r_gnt_sel;
  assign resp_result = r_result;
  assign resp_flags  = r_flags;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: ALU ops, flags, latency, arbitration, hold and reset.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [31:0] resp_result;
  logic [3:0]  resp_flags;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_op     (req0_op),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_op     (req1_op),
    .resp0_valid (resp0_valid),
    .resp0_ready (resp0_ready),
    .resp1_valid (resp1_valid),
    .resp1_ready (resp1_ready),
    .resp_result (resp_result),
    .resp_flags  (resp_flags)
  );

  typedef struct {
    int          n;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  // Drives one request from an IDLE negedge and collects what came back; no checking here.
  task automatic run_op(input int n, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, output logic acc, output int lat,
                        output logic [31:0] res, output logic [3:0] flg);
    if (n == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end
    #1;
    acc = (n == 0) ? req0_ready : req1_ready;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 32'hDEADBEEF; req0_b = 32'h12345678; req0_op = 3'b011;
    req1_a = 32'hDEADBEEF; req1_b = 32'h12345678; req1_op = 3'b011;
    lat = 1;
    while ((((n == 0) ? resp0_valid : resp1_valid) !== 1'b1) && (lat < 10)) begin
      @(negedge clk);
      lat++;
    end
    res = resp_result;
    flg = resp_flags;
    if (n == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
    @(negedge clk);
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; resp0_ready = 1'b0; resp1_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0; req1_a = '0; req1_b = '0; req1_op = '0;
    @(negedge clk);
    @(negedge clk);
    n_tests++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got=%b want=00", {req0_ready, req1_ready}); end
    n_tests++; if ({resp0_valid, resp1_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_valid got=%b want=00", {resp0_valid, resp1_valid}); end
    n_tests++; if (resp_result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h want=0", resp_result); end
    n_tests++; if (resp_flags !== 4'h0) begin n_fail++; $display("FAIL reset_flags got=%b want=0000", resp_flags); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_overflow();
    logic acc; int lat; logic [31:0] res; logic [3:0] flg;
    run_op(0, 32'h7FFFFFFF, 32'h1, 3'b010, acc, lat, res, flg);
    n_tests++; if (acc !== 1'b1) begin n_fail++; $display("FAIL add_ready got=%b want=1", acc); end
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL add_latency got=%0d want=2", lat); end
    n_tests++; if (res !== 32'h80000000) begin n_fail++; $display("FAIL add_result got=%h want=80000000", res); end
    n_tests++; if (flg !== 4'b0110) begin n_fail++; $display("FAIL add_flags got=%b want=0110", flg); end
  endtask

  task automatic test_alu_ops();
    vec_t v[10];
    logic acc; int lat; logic [31:0] res; logic [3:0] flg;
    v[0] = '{1, 32'h5,        32'h5,        3'b110, 32'h0,        4'b0001};
    v[1] = '{1, 32'h3,        32'h7,        3'b111, 32'h1,        4'b0000};
    v[2] = '{0, 32'h80000000, 32'h1,        3'b110, 32'h7FFFFFFF, 4'b0100};
    v[3] = '{1, 32'hFFFFFFFF, 32'h1,        3'b111, 32'h1,        4'b0000};
    v[4] = '{0, 32'hFFFFFFFF, 32'h1,        3'b010, 32'h0,        4'b0001};
    v[5] = '{1, 32'hF0F000FF, 32'h0FF00F0F, 3'b000, 32'h00F0000F, 4'b0000};
    v[6] = '{0, 32'hF0F000FF, 32'h0FF00F0F, 3'b001, 32'hFFF00FFF, 4'b0010};
    v[7] = '{1, 32'hF0F000FF, 32'h0FF00F0F, 3'b011, 32'hFF000FF0, 4'b0010};
    v[8] = '{0, 32'hF0F000FF, 32'h0FF00F0F, 3'b100, 32'h000FF000, 4'b0000};
    v[9] = '{1, 32'h00000009, 32'h00000004, 3'b110, 32'h00000005, 4'b0000};
    for (int i = 0; i < 10; i++) begin
      run_op(v[i].n, v[i].a, v[i].b, v[i].op, acc, lat, res, flg);
      n_tests++; if (acc !== 1'b1 || lat != 2) begin n_fail++; $display("FAIL op%0d_handshake ready=%b lat=%0d want ready=1 lat=2", i, acc, lat); end
      n_tests++; if (res !== v[i].r) begin n_fail++; $display("FAIL op%0d_result got=%h want=%h", i, res, v[i].r); end
      n_tests++; if (flg !== v[i].f) begin n_fail++; $display("FAIL op%0d_flags got=%b want=%b", i, flg, v[i].f); end
    end
  endtask

  task automatic test_illegal_op();
    logic acc; int lat; logic [31:0] res; logic [3:0] flg;
    run_op(0, 32'h1, 32'h2, 3'b101, acc, lat, res, flg);
    n_tests++; if (res !== 32'h0) begin n_fail++; $display("FAIL illegal_result got=%h want=0", res); end
    n_tests++; if (flg !== 4'b1001) begin n_fail++; $display("FAIL illegal_flags got=%b want=1001", flg); end
  endtask

  task automatic test_resp_hold();
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd20; req0_op = 3'b010;
    #1;
    n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL hold_accept got=%b want=1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd3; req1_op = 3'b010;
    resp1_ready = 1'b1;
    #1;
    n_tests++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL hold_exec_ready got=%b want=0", req1_ready); end
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      n_tests++; if (resp0_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid c=%0d got=%b want=1", c, resp0_valid); end
      n_tests++; if (resp_result !== 32'd30) begin n_fail++; $display("FAIL hold_result c=%0d got=%h want=1e", c, resp_result); end
      n_tests++; if (resp_flags !== 4'b0000) begin n_fail++; $display("FAIL hold_flags c=%0d got=%b want=0000", c, resp_flags); end
      n_tests++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL hold_no_grant c=%0d got=%b want=00", c, {req0_ready, req1_ready}); end
      @(negedge clk);
    end
    resp0_ready = 1'b1;
    @(negedge clk);
    resp0_ready = 1'b0;
    #1;
    n_tests++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL hold_next_grant got=%b want=1", req1_ready); end
    n_tests++; if (resp0_valid !== 1'b0) begin n_fail++; $display("FAIL hold_released got=%b want=0", resp0_valid); end
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    #1;
    n_tests++; if (resp1_valid !== 1'b1 || resp_result !== 32'd5) begin n_fail++; $display("FAIL hold_req1_resp valid=%b result=%h want valid=1 result=5", resp1_valid, resp_result); end
    @(negedge clk);
    resp1_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int gnt[4];
    int want[4];
    int ng = 0;
    int last_c = 0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    want = '{0, 0, 0, 0};
`else
    want = '{0, 1, 0, 1};
`endif
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd1;  req0_b = 32'd1; req0_op = 3'b010;
    req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd3; req1_op = 3'b110;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    for (int c = 0; c < 30 && ng < 4; c++) begin
      #1;
      if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
        n_tests++; n_fail++; $display("FAIL rr_both_ready c=%0d got=11 want=one-hot", c);
      end
      if (resp0_valid === 1'b1) begin
        n_tests++; if (resp_result !== 32'd2) begin n_fail++; $display("FAIL rr_resp0 got=%h want=2", resp_result); end
      end
      if (resp1_valid === 1'b1) begin
        n_tests++; if (resp_result !== 32'd7) begin n_fail++; $display("FAIL rr_resp1 got=%h want=7", resp_result); end
      end
      if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
        if (ng > 0) begin
          n_tests++; if (c - last_c != 3) begin n_fail++; $display("FAIL rr_spacing got=%0d want=3", c - last_c); end
        end
        gnt[ng] = req1_ready ? 1 : 0;
        ng++;
        last_c = c;
      end
      @(negedge clk);
    end
    n_tests++; if (ng != 4) begin n_fail++; $display("FAIL rr_grant_count got=%0d want=4", ng); end
    for (int i = 0; i < ng; i++) begin
      n_tests++; if (gnt[i] != want[i]) begin n_fail++; $display("FAIL rr_grant%0d got=%0d want=%0d", i, gnt[i], want[i]); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    resp0_ready = 1'b0; resp1_ready = 1'b0;
  endtask

  task automatic test_reset_in_exec();
    req0_valid = 1'b1; req0_a = 32'd4; req0_b = 32'd4; req0_op = 3'b010;
    #1;
    n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL rstx_accept got=%b want=1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++; if ({req0_ready, req1_ready, resp0_valid, resp1_valid} !== 4'b0000) begin n_fail++; $display("FAIL rstx_handshake got=%b want=0000", {req0_ready, req1_ready, resp0_valid, resp1_valid}); end
    n_tests++; if (resp_result !== 32'h0) begin n_fail++; $display("FAIL rstx_result got=%h want=0", resp_result); end
    n_tests++; if (resp_flags !== 4'h0) begin n_fail++; $display("FAIL rstx_flags got=%b want=0000", resp_flags); end
    resp0_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      n_tests++; if (resp0_valid !== 1'b0 || resp_result !== 32'h0) begin n_fail++; $display("FAIL rstx_no_resp c=%0d valid=%b result=%h want valid=0 result=0", c, resp0_valid, resp_result); end
    end
    resp0_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add_overflow();
    test_alu_ops();
    test_illegal_op();
    test_resp_hold();
    test_back_to_back();
    test_reset_in_exec();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 2, number of requesters; only value 2 is supported.
REQ-002 The block SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-004 The block SHALL have ports reqN_valid, input, 1, request present (N = 0,1).
REQ-005 The block SHALL have ports reqN_ready, output, 1, request accepted this cycle.
REQ-006 The block SHALL have ports reqN_a and reqN_b, input, 32, operands.
REQ-007 The block SHALL have ports reqN_op, input, 3, ALU control code: 010 add, 110 sub, 111 slt, 000 and, 001 or, 011 xor, 100 nor.
REQ-008 The block SHALL have ports respN_valid, output, 1, result pending for requester N.
REQ-009 The block SHALL have ports respN_ready, input, 1, requester N takes the result.
REQ-010 The block SHALL have port resp_result, output, 32, result shared by both responders.
REQ-011 The block SHALL have port resp_flags, output, 4, result flags {err, v, s, z}.

Function
REQ-012 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-013 In IDLE with any reqN_valid high, the block SHALL grant one requester, pulse its reqN_ready for exactly that cycle, capture a/b/op into operand registers and move to EXEC.
REQ-014 In IDLE with no valid request, the block SHALL stay in IDLE with both ready outputs low.
REQ-015 The ready outputs SHALL be combinational from state, valids and priority, and SHALL never be high outside IDLE or for both requesters at once.
REQ-016 In EXEC, the block SHALL drive the ALU from the operand registers, register the result and flags, and move to RESP (EXEC lasts one cycle).
REQ-017 In RESP, the block SHALL hold respN_valid high for the granted N, with resp_result and resp_flags stable, until respN_ready is high, then return to IDLE.
REQ-018 Latency from the accept edge to respN_valid high SHALL be 2 cycles; minimum throughput SHALL be one operation per 3 cycles.
REQ-019 The flag z SHALL be (result == 0).
REQ-020 The flag s SHALL be result[31].
REQ-021 The flag v SHALL be set only for add/sub: signed overflow of a+b, or of a-b, respectively; otherwise v SHALL be 0.
REQ-022 Flags SHALL be computed in this block; the ALU's own flag outputs SHALL NOT be used.
REQ-023 For an illegal op (101), the block SHALL return result 0 and flags 4'b1001 (err=1, z=1).
REQ-024 A request arriving while not in IDLE SHALL wait; reqN_valid SHALL be held by the requester and a/b/op SHALL not be sampled.
REQ-025 A respN_ready raised before respN_valid SHALL have no effect.
REQ-026 With round-robin selected (REQ-031), the requester not granted last SHALL win when both are valid in the same cycle.
REQ-027 The priority pointer SHALL update on each accept.

Reset
REQ-028 While rst_n is low at a clock edge, the FSM SHALL go to IDLE; both ready and valid outputs SHALL be 0; resp_result and resp_flags SHALL be 0; the priority pointer SHALL favour requester 0.
REQ-029 Reset in EXEC or RESP SHALL discard the in-flight operation with no response issued.

Configuration
REQ-030 Macro ALU_ARB_FIXED_PRIO_EN defined: requester 0 SHALL always win simultaneous requests, and no priority pointer SHALL exist.
REQ-031 Macro ALU_ARB_FIXED_PRIO_EN undefined: the round-robin of REQ-026 and REQ-027 SHALL apply.

Structure
REQ-032 Package alu_pkg SHALL hold the ALU op-code constants, the FSM state encoding and the flag bit indices.
REQ-033 The block SHALL contain exactly one instance of sub-module alu32, the existing 32-bit ALU, and no other arithmetic datapath beyond the flag logic.

Verification
REQ-034 Bench SHALL cover: req0 add a=0x7FFFFFFF b=1 -> resp0_valid 2 cycles after accept, result 0x80000000, flags 0110 (v=1, s=1).
REQ-035 Bench SHALL cover: req1 sub a=5 b=5 -> result 0, flags 0001; req1 slt a=3 b=7 -> result 1, flags 0000.
REQ-036 Bench SHALL cover: both requesters valid every cycle, round-robin build, respN_ready=1 -> grants alternate 0,1,0,1; with ALU_ARB_FIXED_PRIO_EN -> grants 0,0,0,0.
REQ-037 Bench SHALL cover: resp0_ready held low 5 cycles -> resp0_valid, result and flags stable throughout, no new reqN_ready pulse.
REQ-038 Bench SHALL cover: op=101 a=1 b=2 -> result 0, flags 1001.
REQ-039 Bench SHALL cover: rst_n low one cycle during EXEC -> next cycle IDLE, all outputs 0, no response issued for the discarded request.
